// File: rtl/i2s_stereo_xcvr.sv
// Slave-mode stereo I2S / left-justified transceiver running on the codec master clock.
// BCLK/WCLK are oversampled; RX words are assembled by slot position, TX bits are picked by slot position.
module i2s_stereo_xcvr #(
  parameter int DATA_W  = 16,
  parameter int LJ_MODE = 0,
  parameter int CNT_W   = 6
) (
  input  logic              AUDIO_MCLK,
  input  logic              RESET,
  input  logic              AUDIO_BCLK,
  input  logic              AUDIO_WCLK,
  input  logic              SDATA_IN,
  output logic              SDATA_OUT,
  input  logic              LOOPBACK,
  output logic [DATA_W-1:0] RX_LEFT,
  output logic [DATA_W-1:0] RX_RIGHT,
  output logic              RX_VALID,
  input  logic [DATA_W-1:0] TX_LEFT,
  input  logic [DATA_W-1:0] TX_RIGHT,
  input  logic              TX_VALID,
  output logic              TX_READY,
  output logic              TX_UNDERRUN
);
  localparam int OFF = 1 - LJ_MODE;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {WAIT_SYNC, LEFT, RIGHT} state_t;

  state_t              state_reg, state_next;
  logic [2:0]          bclk_sync_reg, wclk_sync_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [31:0]         cnt_ext;
  logic [DATA_W-1:0]   rx_shift_reg, rx_shift_next, rx_left_reg, rx_right_reg;
  logic [DATA_W-1:0]   hold_left_reg, hold_right_reg;
  logic [DATA_W-1:0]   tx_left_reg, tx_right_reg, tx_left_next, tx_right_next;
  logic [DATA_W-1:0]   tx_word, tx_word_next, pos_hit, tx_pos_bits;
  logic                rx_valid_reg, hold_full_reg, sel_right_reg, sel_right_next;
  logic                underrun_reg, sdata_out_reg;
  logic                brise, bfall, wrise, wfall, w_event;
  logic                frame_load, to_right, latch_right, xfer, tx_bit, slot0_bit;

  // Stages [0],[1] synchronise, [2] is the edge-detect history.
  always_ff @(posedge AUDIO_MCLK or posedge RESET) begin
    if (RESET) begin
      bclk_sync_reg <= '0;
      wclk_sync_reg <= '0;
    end else begin
      bclk_sync_reg <= {bclk_sync_reg[1:0], AUDIO_BCLK};
      wclk_sync_reg <= {wclk_sync_reg[1:0], AUDIO_WCLK};
    end
  end

  assign brise   = bclk_sync_reg[1] & ~bclk_sync_reg[2];
  assign bfall   = ~bclk_sync_reg[1] & bclk_sync_reg[2];
  assign wrise   = wclk_sync_reg[1] & ~wclk_sync_reg[2];
  assign wfall   = ~wclk_sync_reg[1] & wclk_sync_reg[2];
  assign w_event = wrise | wfall;
  assign cnt_ext = 32'(cnt_reg);

  // Word bit gi lives at slot position OFF + DATA_W-1-gi, for both directions.
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pos
      localparam logic [31:0] POS = 32'(OFF + DATA_W - 1 - gi);
      assign pos_hit[gi]     = (cnt_ext == POS);
      assign tx_pos_bits[gi] = pos_hit[gi] & tx_word[gi];
    end
  endgenerate

  assign rx_shift_next = (rx_shift_reg & ~(pos_hit & {DATA_W{brise}}))
                       | (pos_hit & {DATA_W{brise & SDATA_IN}});
  assign tx_bit  = |tx_pos_bits;
  assign tx_word = sel_right_reg ? tx_right_reg : tx_left_reg;
  assign xfer    = TX_VALID & ~hold_full_reg;

  always_comb begin
    state_next  = state_reg;
    frame_load  = 1'b0;
    to_right    = 1'b0;
    latch_right = 1'b0;
    case (state_reg)
      WAIT_SYNC: if (wfall) begin
        state_next = LEFT;
        frame_load = 1'b1;
      end
      LEFT: if (wrise) begin
        state_next = RIGHT;
        to_right   = 1'b1;
      end
      RIGHT: if (wfall) begin
        state_next  = LEFT;
        frame_load  = 1'b1;
        latch_right = 1'b1;
      end
      default: state_next = WAIT_SYNC;
    endcase
  end

  // A pair accepted in the load cycle bypasses the holding register.
  always_comb begin
    tx_left_next   = tx_left_reg;
    tx_right_next  = tx_right_reg;
    sel_right_next = sel_right_reg;
    if (frame_load) begin
      sel_right_next = 1'b0;
      if (xfer) begin
        tx_left_next  = TX_LEFT;
        tx_right_next = TX_RIGHT;
      end else if (hold_full_reg) begin
        tx_left_next  = hold_left_reg;
        tx_right_next = hold_right_reg;
      end
    end
    if (to_right) sel_right_next = 1'b1;
    tx_word_next = sel_right_next ? tx_right_next : tx_left_next;
    slot0_bit    = (LJ_MODE != 0) & tx_word_next[DATA_W-1];
  end

  always_ff @(posedge AUDIO_MCLK or posedge RESET) begin
    if (RESET) begin
      state_reg      <= WAIT_SYNC;
      cnt_reg        <= '0;
      rx_shift_reg   <= '0;
      rx_left_reg    <= '0;
      rx_right_reg   <= '0;
      rx_valid_reg   <= 1'b0;
      hold_left_reg  <= '0;
      hold_right_reg <= '0;
      hold_full_reg  <= 1'b0;
      tx_left_reg    <= '0;
      tx_right_reg   <= '0;
      sel_right_reg  <= 1'b0;
      underrun_reg   <= 1'b0;
      sdata_out_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tx_left_reg   <= tx_left_next;
      tx_right_reg  <= tx_right_next;
      sel_right_reg <= sel_right_next;
      rx_valid_reg  <= latch_right;
      underrun_reg  <= frame_load & ~xfer & ~hold_full_reg;

      if (w_event) cnt_reg <= '0;
      else if (brise && cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 1'b1;

      if (to_right) rx_left_reg <= rx_shift_reg;
      if (latch_right) rx_right_reg <= rx_shift_reg;
      rx_shift_reg <= w_event ? '0 : rx_shift_next;

      if (frame_load) hold_full_reg <= 1'b0;
      else if (xfer) begin
        hold_full_reg  <= 1'b1;
        hold_left_reg  <= TX_LEFT;
        hold_right_reg <= TX_RIGHT;
      end

      if (w_event) sdata_out_reg <= slot0_bit;
      else if (bfall) sdata_out_reg <= tx_bit;
    end
  end

  assign SDATA_OUT   = LOOPBACK ? SDATA_IN : sdata_out_reg;
  assign RX_LEFT     = rx_left_reg;
  assign RX_RIGHT    = rx_right_reg;
  assign RX_VALID    = rx_valid_reg;
  assign TX_READY    = ~hold_full_reg;
  assign TX_UNDERRUN = underrun_reg;
endmodule

// File: doc/i2s_stereo_xcvr.md
Name: i2s_stereo_xcvr

Overview:
- Parametrised stereo I2S transceiver clocked by the codec master clock, for slave-mode links where the codec supplies BCLK/WCLK.
- Deserialises SDATA_IN into left/right words of DATA_W bits.
- Serialises a handshaked left/right sample pair onto SDATA_OUT.
- Supports I2S (one-bit delay) or left-justified framing, with a combinational loopback bypass.
- Sits between the audio codec pins and the FM modulator / sample-source logic.

Parameters:
DATA_W, 16, sample word width (1..32)
LJ_MODE, 0, 0 = I2S (MSB at slot position 1), 1 = left-justified (MSB at slot position 0)
CNT_W, 6, slot bit-counter width; counter saturates at 2^CNT_W-1

Ports:
AUDIO_MCLK  in  1  master clock, sole clock; must be ≥4x BCLK
RESET  in  1  asynchronous, active-high reset
AUDIO_BCLK  in  1  codec bit clock (asynchronous, sampled)
AUDIO_WCLK  in  1  codec word clock; low = left, high = right
SDATA_IN  in  1  serial data from codec ADC
SDATA_OUT  out  1  serial data to codec DAC
LOOPBACK  in  1  1: SDATA_OUT = SDATA_IN combinationally
RX_LEFT  out  DATA_W  last complete left word
RX_RIGHT  out  DATA_W  last complete right word
RX_VALID  out  1  one-cycle strobe: RX_LEFT/RX_RIGHT hold a new frame
TX_LEFT  in  DATA_W  left sample to transmit
TX_RIGHT  in  DATA_W  right sample to transmit
TX_VALID  in  1  TX pair offered
TX_READY  out  1  holding register empty
TX_UNDERRUN  out  1  one-cycle strobe: frame started with no new TX pair

Behaviour:
- Reset values: RX_LEFT = 0, RX_RIGHT = 0, RX_VALID = 0, TX_READY = 1, TX_UNDERRUN = 0. SDATA_OUT register = 0. Bit counter = 0, TX shifters/holding = 0, state = WAIT_SYNC.
- BCLK/WCLK pass through 2-FF synchronisers plus an edge register. Events (BRISE, BFALL, WRISE, WFALL) are single-cycle and occur 3 MCLK cycles after the pin edge.
- Slot position p: counter cleared on any W event. Incremented on BRISE when no W event occurs in the same cycle. Saturates at 2^CNT_W-1 with no wrap.
- OFF = 1 - LJ_MODE.
- RX:
  - On BRISE with OFF ≤ p < OFF+DATA_W, SDATA_IN is written to rx shift bit DATA_W-1-(p-OFF).
  - Positions outside this window are ignored.
  - Bits not received because the slot was short stay 0; the shifter is cleared on every W event after its latch.
- TX:
  - On a W event, SDATA_OUT is set to the bit for position 0.
  - On BFALL (no W event in the same cycle), SDATA_OUT is set to the bit for position = current counter.
  - Position k drives tx word bit DATA_W-1-(k-OFF) inside the window, and 0 outside it.
- FSM:
  - WAIT_SYNC: on WFALL go to LEFT. Load the TX frame; no RX latch, no RX_VALID.
  - LEFT: on WRISE, latch the rx shifter into RX_LEFT, select the right TX word, go to RIGHT.
  - RIGHT: on WFALL, latch RX_RIGHT, pulse RX_VALID in the same cycle, load a new TX frame, go to LEFT.
  - A WRISE seen in RIGHT, or a WFALL seen in LEFT, is impossible given the synchroniser; ignore it.
- TX handshake:
  - A transfer occurs when TX_VALID & TX_READY. Both words go into the holding register and TX_READY drops the next cycle.
  - At frame load with holding full: copy to the TX shifters and raise TX_READY the next cycle.
  - At frame load with holding empty: resend the previous pair and pulse TX_UNDERRUN.
  - A transfer in the same cycle as a frame load is consumed by that load directly; TX_READY stays 1.
- LOOPBACK has no effect on the RX path, the FSM, or the handshake.
- Reset mid-frame returns to WAIT_SYNC; the first RX_VALID requires a full L+R frame after reset release.

Test Plan:
- DATA_W=16, I2S mode, BCLK = MCLK/8, 32-bit slots, codec sends L=16'hA5C3, R=16'h0F01 → RX_LEFT=A5C3 and RX_RIGHT=0F01, one RX_VALID per frame, first valid after the second WFALL following reset.
- Same link, TX pair 16'h8001/16'h7FFE offered once → SDATA_OUT MSB at p=1 of each slot, zeros at p=0 and p≥17, TX_READY returns to 1 after the frame load.
- No TX_VALID for 3 frames after one transfer of 16'h1234/16'h5678 → the same pair is repeated, one TX_UNDERRUN pulse per frame.
- LJ_MODE=1, DATA_W=24, codec sends 24'h800001 → RX_LEFT=800001, MSB captured at p=0.
- DATA_W=24 with 16-bit slots, codec sends 16'hFFFF → RX_LEFT=24'hFFFF00, counter behaviour unaffected.
- LOOPBACK=1 → SDATA_OUT tracks SDATA_IN within 0 cycles. Also assert RESET mid-left-slot → all outputs return to reset values and no RX_VALID until a full new frame has passed.
